// File: rtl/traffic_pkg.sv
// Lamp encodings and sequencer state codes shared by the sequencer and its timer.
// Combinational definitions only: no latency, no backpressure.
package traffic_pkg;

    localparam logic [1:0] LITE_RED    = 2'b00;
    localparam logic [1:0] LITE_GREEN  = 2'b01;
    localparam logic [1:0] LITE_YELLOW = 2'b10;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter with synchronous clear and a compare against a selected last-count limit.
// Count updates one cycle after clear; compare is combinational on the count; no backpressure.
module phase_timer #(
    parameter int CNT_W = 5,
    parameter int SAT   = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             reached
);

    localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != SAT_V) begin
            count <= count + 1'b1;
        end
    end

    assign reached = (count >= limit);

endmodule

// File: rtl/intersection_phase_sequencer.sv
// Two-way intersection sequencer: green/yellow/all-red rotation with min/max green and a pedestrian walk.
// Lamps, walk and ped_ack are registered from the next state (one-cycle latency); no backpressure.
module intersection_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN    = 8,
    parameter int MAX_GREEN    = 20,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 6,
    parameter int CNT_W        = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    // Limits are the last count value of a phase, since the count is 0 on its first visible cycle.
    localparam logic [CNT_W-1:0] LIM_MIN = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] LIM_MAX = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] LIM_Y   = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] LIM_AR  = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] LIM_W   = CNT_W'(WALK_TIME - 1);

    state_t           state;
    state_t           nxt;
    dir_t             last_dir;
    logic             ped_pending;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit;
    logic             reached;
    logic             min_ok;

    phase_timer #(
        .CNT_W (CNT_W),
        .SAT   (MAX_GREEN)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (nxt != state),
        .limit   (limit),
        .count   (count),
        .reached (reached)
    );

    assign min_ok = (count >= LIM_MIN);

    always_comb begin
        nxt   = state;
        limit = LIM_AR;
        case (state)
            ALL_RED: begin
                limit = LIM_AR;
                if (reached) begin
                    if (ped_pending)             nxt = PED_WALK;
                    else if (last_dir == DIR_EW) nxt = NS_GREEN;
                    else                         nxt = EW_GREEN;
                end
            end
            // The timer tracks MAX; MIN is compared directly against the count.
            NS_GREEN: begin
                limit = LIM_MAX;
                if ((ew_car | ped_pending) && ((min_ok && !ns_car) || reached)) nxt = NS_YELLOW;
            end
            EW_GREEN: begin
                limit = LIM_MAX;
                if ((ns_car | ped_pending) && ((min_ok && !ew_car) || reached)) nxt = EW_YELLOW;
            end
            NS_YELLOW, EW_YELLOW: begin
                limit = LIM_Y;
                if (reached) nxt = ALL_RED;
            end
            PED_WALK: begin
                limit = LIM_W;
                if (reached) nxt = ALL_RED;
            end
            default: nxt = ALL_RED;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ALL_RED;
            last_dir    <= DIR_EW;
            ped_pending <= 1'b0;
            ns_light    <= LITE_RED;
            ew_light    <= LITE_RED;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == NS_GREEN)      last_dir <= DIR_NS;
            else if (nxt == EW_GREEN) last_dir <= DIR_EW;
            // Entry to the walk wins over a request seen on the same cycle.
            if (nxt == PED_WALK && state != PED_WALK)  ped_pending <= 1'b0;
            else if (ped_req && state != PED_WALK)     ped_pending <= 1'b1;
            ns_light <= (nxt == NS_GREEN)  ? LITE_GREEN  :
                        (nxt == NS_YELLOW) ? LITE_YELLOW : LITE_RED;
            ew_light <= (nxt == EW_GREEN)  ? LITE_GREEN  :
                        (nxt == EW_YELLOW) ? LITE_YELLOW : LITE_RED;
            walk     <= (nxt == PED_WALK);
            ped_ack  <= (nxt == PED_WALK) && (state != PED_WALK);
        end
    end

    assign phase = state;

endmodule

// File: doc/intersection_phase_sequencer.md
# intersection_phase_sequencer

Sequences a two-way intersection (north-south and east-west) through green, yellow and all-red clearance phases, plus an optional pedestrian walk phase. Car sensors and a pedestrian request handshake feed it, and its registered outputs drive the lamp heads. Minimum and maximum green times bound how long each direction holds the intersection. Clearance ordering is round-robin, so neither direction can starve the other.

## Interface
- MIN_GREEN, 8: cycles a green holds before it may yield; yields only if there is demand and its own direction has no car.
- MAX_GREEN, 20: cycles after which a green yields to demand even when its own car is present.
- YELLOW_TIME, 3: yellow phase length in cycles.
- ALL_RED_TIME, 1: all-red clearance length in cycles.
- WALK_TIME, 6: pedestrian walk phase length in cycles.
- CNT_W, 5: width of the phase counter; must hold MAX_GREEN.
- clock  in  1  the single clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- ns_car  in  1  level input; a car is waiting or present on the north-south approach.
- ew_car  in  1  level input; a car is waiting or present on the east-west approach.
- ped_req  in  1  pedestrian request; held high until ped_ack is seen.
- ped_ack  out  1  one-cycle pulse on the first cycle of the walk phase.
- ns_light  out  2  north-south lamp: 00 red, 01 green, 10 yellow (11 is never driven).
- ew_light  out  2  east-west lamp, same encoding as ns_light.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state code, for debug and bench observation.

## Operation
- States: ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK.
- Lamps per state:
  - In ALL_RED and PED_WALK, both lamps are red.
  - In the NS states, ew_light is red; in the EW states, ns_light is red.
  - walk is 1 only in PED_WALK.
- Register ped_pending:
  - Set on any cycle where ped_req=1 and the state is not PED_WALK.
  - Cleared on entry to PED_WALK.
- Register last_dir records the direction that was green most recently.
- Green exit. Let own = the car input for the green direction and demand = (opposing car | ped_pending). Go to yellow when either holds:
  - the phase count is at least MIN_GREEN, demand=1 and own=0;
  - the phase count reaches MAX_GREEN with demand=1.
- With no demand, green holds indefinitely; the counter saturates at MAX_GREEN.
- Yellow lasts exactly YELLOW_TIME cycles, then goes to ALL_RED.
- Leaving ALL_RED after ALL_RED_TIME cycles:
  - If ped_pending is set, go to PED_WALK.
  - Otherwise go green in the direction opposite last_dir.
- PED_WALK lasts WALK_TIME cycles, then goes to ALL_RED. last_dir is unchanged, so the other direction is served next.
- Lamps never go directly from a green state to the opposing green. Every transition passes through yellow and ALL_RED.
- Simultaneous ns_car and ew_car do not affect the order; alternation is fixed by last_dir.
- A ped_req that rises during PED_WALK does not set ped_pending; it is taken once the walk ends.

## Timing
- Reset values: state ALL_RED, counter 0, last_dir=EW, ped_pending=0, ns_light=ew_light=00, walk=0, ped_ack=0, phase=ALL_RED code.
- Reset may assert asynchronously in any state and forces all of the above at once. The first green after release is NS.
- All outputs are registered.
- Each fixed phase lasts exactly its parameter in cycles, counted from the first cycle its lamp values are visible.
- Green decisions use the ns_car, ew_car and ped_pending values sampled in that cycle. Yellow becomes visible on the next cycle.
- ped_ack is high for exactly one cycle, coinciding with the first cycle of walk=1.
- The pedestrian wait is bounded by the remaining green time (at most MAX_GREEN) plus YELLOW_TIME plus ALL_RED_TIME.
- The phase counter clears on every state change.

## Structure
- Package traffic_pkg holds the lamp encodings (LITE_RED, LITE_GREEN, LITE_YELLOW) and the state enum with the 3-bit codes driven on phase.
- Sub-module phase_timer is a CNT_W-bit saturating up-counter with a clear input. It produces the count and a compare against a selected limit, and is instantiated once.
- The sequencer holds the FSM, ped_pending, last_dir and the output registers.

## Test plan
- Reset release with no cars: after 1 cycle of ALL_RED, ns_light=01 and it holds for 100 cycles; ew_light=00 and walk=0 throughout.
- ew_car=1 with ns_car=0 during NS green: NS yellow starts at count 8 and lasts 3 cycles, then 1 cycle of all red, then ew_light=01.
- ns_car=1 and ew_car=1 held continuously: each green lasts 20 cycles and each yellow 3. The sequence alternates NS, EW, NS with no direct green-to-green transition.
- ped_req pulse held until ack during NS green with ns_car=0: NS yellow at count 8, then all red, then walk=1 for 6 cycles with ped_ack for 1 cycle, then all red, then EW green.
- Assert reset_n low mid-yellow: both lamps go to 00 immediately without waiting for a clock edge. After release, the first green is NS.
- ped_req high throughout PED_WALK: exactly one further walk is served after the next green, not two back to back.
